// File: rtl/aes_cipher_iter.sv
// Iterative AES block cipher: one round per clock, encrypt or decrypt chosen per block.
// The caller supplies the fully expanded key schedule; no key expansion happens here.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   k_sch      expanded round keys, k_sch[r] = round key r (FIPS-197 byte order)
//   in_valid   block offered          in_ready   high only while idle
//   in_mode    0 encrypt, 1 decrypt   in_data    plaintext or ciphertext
//   out_valid  result available       out_ready  consumer takes the result
//   out_data   result block, held stable until taken
module aes_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR:0][127:0] k_sch,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data
);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end
  if (NR != NK + 6) begin : g_bad_nr
    $error("aes_cipher_iter: NR is derived from NK and must not be overridden");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Byte i of the state lives at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv ? INV_SBOX[s[127-8*i -: 8]] : SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Row r rotates left by r columns (right by r when inverting).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  // Forward coefficients {2,3,1,1}; inverse {e,b,d,9} built from xtime chains.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   x2[4];
    logic [7:0]   x4[4];
    logic [7:0]   x8[4];
    int j1, j2, j3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[127-8*(4*c+i) -: 8];
        x2[i] = xtime(a[i]);
        x4[i] = xtime(x2[i]);
        x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
        j1 = (i + 1) % 4;
        j2 = (i + 2) % 4;
        j3 = (i + 3) % 4;
        if (!inv) begin
          o[127-8*(4*c+i) -: 8] = x2[i] ^ x2[j1] ^ a[j1] ^ a[j2] ^ a[j3];
        end else begin
          o[127-8*(4*c+i) -: 8] = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
                                  (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
        end
      end
    end
    return o;
  endfunction

  state_e       r_state;
  state_e       w_state_next;
  logic         r_mode;
  logic [3:0]   r_round;
  logic [127:0] r_data;

  logic         w_last;
  logic [3:0]   w_key_idx;
  logic [127:0] w_rkey;
  logic [127:0] w_enc_sr;
  logic [127:0] w_dec_t;
  logic [127:0] w_round_out;
  logic [127:0] w_load;

  assign w_last    = (r_round == 4'(NR));
  // Decrypt walks the schedule backwards; its final round lands on k_sch[0] naturally.
  assign w_key_idx = r_mode ? 4'(NR) - r_round : r_round;
  assign w_rkey    = k_sch[w_key_idx];
  assign w_load    = in_data ^ (in_mode ? k_sch[NR] : k_sch[0]);
  assign out_data  = r_data;

  always_comb begin
    w_enc_sr    = shift_rows(sub_bytes(r_data, 1'b0), 1'b0);
    w_dec_t     = sub_bytes(shift_rows(r_data, 1'b1), 1'b1) ^ w_rkey;
    w_round_out = '0;
    if (r_mode) begin
      w_round_out = w_last ? w_dec_t : mix_columns(w_dec_t, 1'b1);
    end else begin
      w_round_out = (w_last ? w_enc_sr : mix_columns(w_enc_sr, 1'b0)) ^ w_rkey;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StBusy;
      end
      StBusy: begin
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_mode  <= 1'b0;
      r_round <= 4'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && in_valid) begin
        r_mode  <= in_mode;
        r_data  <= w_load;
        r_round <= 4'd1;
      end else if (r_state == StBusy) begin
        r_data  <= w_round_out;
        r_round <= w_last ? 4'd0 : r_round + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: known-answer blocks for NK = 4/6/8 in both directions,
// backpressure hold, reset behaviour, and a randomised scoreboard run on the NK = 4 unit.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [14:0][127:0]  ks4, ks6, ks8;
  logic [2:0]          vld, md, ordy;
  logic [2:0][127:0]   din;
  logic                irdy0, irdy1, irdy2, ovld0, ovld1, ovld2;
  logic [127:0]        dout0, dout1, dout2;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   sbox[256];

  aes_cipher_iter #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .k_sch(ks4[10:0]), .in_valid(vld[0]), .in_ready(irdy0),
    .in_mode(md[0]), .in_data(din[0]), .out_valid(ovld0), .out_ready(ordy[0]), .out_data(dout0)
  );
  aes_cipher_iter #(.NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .k_sch(ks6[12:0]), .in_valid(vld[1]), .in_ready(irdy1),
    .in_mode(md[1]), .in_data(din[1]), .out_valid(ovld1), .out_ready(ordy[1]), .out_data(dout1)
  );
  aes_cipher_iter #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .k_sch(ks8), .in_valid(vld[2]), .in_ready(irdy2),
    .in_mode(md[2]), .in_data(din[2]), .out_valid(ovld2), .out_ready(ordy[2]), .out_data(dout2)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_irdy(input int i);
    case (i)
      0: return irdy0;
      1: return irdy1;
      default: return irdy2;
    endcase
  endfunction

  function automatic logic get_ovld(input int i);
    case (i)
      0: return ovld0;
      1: return ovld1;
      default: return ovld2;
    endcase
  endfunction

  function automatic logic [127:0] get_dout(input int i);
    case (i)
      0: return dout0;
      1: return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from the field inverse plus affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Key bytes are 00, 01, 02, ... for every key length.
  task automatic expand(input int nk, output logic [14:0][127:0] ks);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr   = nk + 6;
    rcon = 8'h01;
    ks   = '0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input int nk, input logic [127:0] pt,
                                             input logic [14:0][127:0] ks);
    logic [7:0]   st[16];
    logic [7:0]   tmp[16];
    logic [7:0]   a[4];
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ ks[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*((c+row)%4)+row];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = st[4*c+i];
          for (int i = 0; i < 4; i++)
            st[4*c+i] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ ks[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  // Offer one block, check latency and result, optionally hold out_ready low for `stall`
  // cycles while toggling the input side, then release.
  task automatic run_block(input int idx, input logic mode, input logic [127:0] data,
                           input logic [127:0] exp, input int lat, input int stall);
    int n;
    logic [127:0] held;
    ordy[idx] = (stall == 0);
    check_eq($sformatf("u%0d_idle_in_ready", idx), 128'(get_irdy(idx)), 128'd1);
    vld[idx] = 1'b1;
    md[idx]  = mode;
    din[idx] = data;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    vld[idx] = 1'b0;
    md[idx]  = ~mode;
    din[idx] = rand128();
    n = 1;
    while (!get_ovld(idx) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("u%0d_latency", idx), 128'(n), 128'(lat));
    held = sb_q.pop_front();
    check_eq($sformatf("u%0d_result", idx), get_dout(idx), held);
    check_eq($sformatf("u%0d_done_in_ready", idx), 128'(get_irdy(idx)), 128'd0);
    for (int k = 0; k < stall; k++) begin
      vld[idx] = 1'($urandom_range(0, 1));
      md[idx]  = 1'($urandom_range(0, 1));
      din[idx] = rand128();
      @(posedge clk); #1;
      check_eq($sformatf("u%0d_hold_valid", idx), 128'(get_ovld(idx)), 128'd1);
      check_eq($sformatf("u%0d_hold_data", idx), get_dout(idx), held);
      check_eq($sformatf("u%0d_hold_in_ready", idx), 128'(get_irdy(idx)), 128'd0);
    end
    vld[idx]  = 1'b0;
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    check_eq($sformatf("u%0d_post_out_valid", idx), 128'(get_ovld(idx)), 128'd0);
    check_eq($sformatf("u%0d_post_in_ready", idx), 128'(get_irdy(idx)), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    int got;
    int sent;
    rst  = 1'b1;
    vld  = '0;
    md   = '0;
    ordy = '1;
    din  = '0;
    build_sbox();
    expand(4, ks4);
    expand(6, ks6);
    expand(8, ks8);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(irdy0), 128'd1);
    check_eq("rst_out_valid", 128'(ovld0), 128'd0);
    check_eq("rst_out_data", dout0, 128'd0);
    check_eq("rst_in_ready_nk8", 128'(irdy2), 128'd1);
    check_eq("rst_out_data_nk8", dout2, 128'd0);
    rst = 1'b0;

    run_block(0, 1'b0, PT, CT4, 11, 0);
    run_block(1, 1'b0, PT, CT6, 13, 0);
    run_block(2, 1'b0, PT, CT8, 15, 0);
    run_block(0, 1'b1, CT4, PT, 11, 0);
    run_block(1, 1'b1, CT6, PT, 13, 0);
    run_block(2, 1'b1, CT8, PT, 15, 0);

    run_block(0, 1'b0, PT, CT4, 11, 20);

    // Reset while round 5 is executing.
    vld[0] = 1'b1; md[0] = 1'b0; din[0] = PT;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_in_ready", 128'(irdy0), 128'd1);
    check_eq("midrst_out_valid", 128'(ovld0), 128'd0);
    check_eq("midrst_out_data", dout0, 128'd0);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ovld0) stray++;
    end
    check_eq("midrst_no_pulse", 128'(stray), 128'd0);
    run_block(0, 1'b1, CT4, PT, 11, 0);

    // Reset wins over a simultaneous handshake.
    vld[0] = 1'b1; md[0] = 1'b0; din[0] = PT;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vld[0] = 1'b0;
    check_eq("rstpri_in_ready", 128'(irdy0), 128'd1);
    stray = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ovld0) stray++;
    end
    check_eq("rstpri_no_pulse", 128'(stray), 128'd0);

    // Random back-to-back blocks with random output stalls.
    got  = 0;
    sent = 0;
    fork
      begin
        logic [127:0] pt, ct;
        logic m;
        int g;
        for (int i = 0; i < 1000; i++) begin
          pt = rand128();
          m  = 1'($urandom_range(0, 1));
          ct = model_enc(4, pt, ks4);
          vld[0] = 1'b1;
          md[0]  = m;
          din[0] = m ? ct : pt;
          g = 0;
          while (!irdy0 && g < 200) begin
            @(posedge clk); #1;
            g++;
          end
          check_eq("rand_drv_ready", 128'(irdy0), 128'd1);
          if (!irdy0) break;
          sb_q.push_back(m ? pt : ct);
          @(posedge clk); #1;
          vld[0] = 1'b0;
          sent++;
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        int idle;
        idle = 0;
        while (got < 1000 && idle < 500) begin
          ordy[0] = ($urandom_range(0, 3) != 0);
          if (ovld0 && ordy[0]) begin
            check_eq("rand_sb_nonempty", 128'(sb_q.size() > 0), 128'd1);
            if (sb_q.size() > 0) check_eq("rand_result", dout0, sb_q.pop_front());
            got++;
            idle = 0;
          end else begin
            idle++;
          end
          @(posedge clk); #1;
        end
      end
    join
    ordy[0] = 1'b1;
    check_eq("rand_sent", 128'(sent), 128'd1000);
    check_eq("rand_received", 128'(got), 128'd1000);
    check_eq("rand_leftover", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
